// File: rtl/matrix_sram_ctrl.sv
// Burst controller between a command/stream interface and a single-port SRAM.
// Write bursts stream straight into the SRAM; read bursts go through a 2-entry skid FIFO.
module matrix_sram_ctrl #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic          wd_valid,
  output logic          wd_ready,
  input  logic [DW-1:0] wd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          busy,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_din,
  output logic [DW-1:0] sram_bm,
  output logic          sram_men,
  output logic          sram_wen,
  output logic          sram_ren,
  input  logic [DW-1:0] sram_dout
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  localparam logic [AW-1:0] ONE = AW'(1);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          inFlight_q, inFlight_d;
  logic          inFlightLast_q, inFlightLast_d;
  logic          armed_q;

  logic [DW-1:0] fifoData_q [2];
  logic [1:0]    fifoLast_q;
  logic          wrPtr_q, rdPtr_q;
  logic [1:0]    occ_q;

  logic          push, pop, wrHs, issue;
  logic [2:0]    pending;

  assign push = inFlight_q;
  assign pop  = (occ_q != 2'd0) && rd_ready;
  assign wrHs = (state_q == WRITE) && wd_valid;

  // A slot freed by this cycle's pop can be reused at once, which keeps reads at one word per cycle
  assign pending = 3'(occ_q) - 3'(pop) + 3'(inFlight_q);
  assign issue   = (state_q == READ) && (pending < 3'd2);

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    cnt_d          = cnt_q;
    inFlight_d     = 1'b0;
    inFlightLast_d = inFlightLast_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && armed_q) begin
          addr_d  = cmd_addr;
          cnt_d   = cmd_len;
          state_d = cmd_op ? READ : WRITE;
        end
      end
      WRITE: begin
        if (wrHs) begin
          addr_d = addr_q + ONE;
          cnt_d  = cnt_q - ONE;
          if (cnt_q == '0) state_d = IDLE;
        end
      end
      READ: begin
        if (issue) begin
          inFlight_d     = 1'b1;
          inFlightLast_d = (cnt_q == '0);
          addr_d         = addr_q + ONE;
          cnt_d          = cnt_q - ONE;
          if (cnt_q == '0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((occ_q == 2'd0) && !inFlight_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      cnt_q          <= '0;
      inFlight_q     <= 1'b0;
      inFlightLast_q <= 1'b0;
      armed_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      cnt_q          <= cnt_d;
      inFlight_q     <= inFlight_d;
      inFlightLast_q <= inFlightLast_d;
      armed_q        <= 1'b1;
    end
  end

  // Returning SRAM words are captured one cycle after issue; reset drops anything still in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifoData_q[0] <= '0;
      fifoData_q[1] <= '0;
      fifoLast_q    <= '0;
      wrPtr_q       <= 1'b0;
      rdPtr_q       <= 1'b0;
      occ_q         <= 2'd0;
    end else begin
      if (push) begin
        fifoData_q[wrPtr_q] <= sram_dout;
        fifoLast_q[wrPtr_q] <= inFlightLast_q;
        wrPtr_q             <= ~wrPtr_q;
      end
      if (pop) rdPtr_q <= ~rdPtr_q;
      occ_q <= occ_q + 2'(push) - 2'(pop);
    end
  end

  assign cmd_ready = (state_q == IDLE) && armed_q;
  assign wd_ready  = (state_q == WRITE);
  assign busy      = (state_q != IDLE);
  assign rd_valid  = (occ_q != 2'd0);
  assign rd_data   = fifoData_q[rdPtr_q];
  assign rd_last   = fifoLast_q[rdPtr_q];
  assign sram_addr = addr_q;
  assign sram_din  = wrHs ? wd_data : '0;
  assign sram_bm   = '1;
  assign sram_wen  = wrHs;
  assign sram_ren  = issue;
  assign sram_men  = wrHs | issue;

endmodule

// File: tb/tb_matrix_sram_ctrl.sv
// Randomized bench for matrix_sram_ctrl with a behavioural SRAM and a flat reference memory.
module tb_matrix_sram_ctrl;

  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_op;
  logic [AW-1:0] cmd_addr, cmd_len;
  logic          wd_valid, wd_ready;
  logic [DW-1:0] wd_data;
  logic          rd_valid, rd_ready, rd_last, busy;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din, sram_bm;
  logic          sram_men, sram_wen, sram_ren;
  logic [DW-1:0] sram_dout = '0;

  logic [DW-1:0] sramMem [DEPTH];
  logic [DW-1:0] refMem  [DEPTH];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  matrix_sram_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_bm(sram_bm),
    .sram_men(sram_men), .sram_wen(sram_wen), .sram_ren(sram_ren),
    .sram_dout(sram_dout)
  );

  // Behavioural single-port SRAM with one cycle of read latency
  always @(posedge clk) begin
    if (sram_men && sram_wen) sramMem[sram_addr] <= sram_din;
    if (sram_men && sram_ren) sram_dout <= sramMem[sram_addr];
  end

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Rules that hold on every cycle
  always @(negedge clk) begin
    #2;
    checkOutput("wen_ren_excl", DW'(sram_wen & sram_ren), '0);
    checkOutput("men_rule", DW'(sram_men), DW'(sram_wen | sram_ren));
    checkOutput("bm_ones", sram_bm, '1);
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_cmd_ready"}, DW'(cmd_ready), '0);
    checkOutput({tag, "_wd_ready"},  DW'(wd_ready),  '0);
    checkOutput({tag, "_rd_valid"},  DW'(rd_valid),  '0);
    checkOutput({tag, "_rd_last"},   DW'(rd_last),   '0);
    checkOutput({tag, "_busy"},      DW'(busy),      '0);
    checkOutput({tag, "_wen"},       DW'(sram_wen),  '0);
    checkOutput({tag, "_ren"},       DW'(sram_ren),  '0);
    checkOutput({tag, "_men"},       DW'(sram_men),  '0);
    checkOutput({tag, "_addr"},      DW'(sram_addr), '0);
    checkOutput({tag, "_din"},       sram_din,       '0);
    checkOutput({tag, "_rd_data"},   rd_data,        '0);
  endtask

  // Offers a command and returns just after the accepting clock edge
  task automatic applyStimulus(input logic op, input int a, input int len);
    int waitCnt = 0;
    logic seen = 1'b0;
    while (!seen && waitCnt < 50) begin
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = AW'(a);
      cmd_len   = AW'(len);
      #1;
      seen = cmd_ready;
      waitCnt++;
    end
    checkOutput("cmd_accept", DW'(seen), DW'(1));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic doWrite(input int a, input int len, input bit gaps, input logic [DW-1:0] base, input bit rnd);
    int i = 0;
    int cyc = 0;
    logic v;
    logic [DW-1:0] d;
    logic [AW-1:0] ea;
    applyStimulus(1'b0, a, len);
    while (i <= len && cyc < 4 * (len + 1) + 20) begin
      @(negedge clk);
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      d = rnd ? $urandom : base + DW'(i);
      wd_valid = v;
      wd_data  = d;
      #1;
      checkOutput("wr_wd_ready", DW'(wd_ready), DW'(1));
      if (v) begin
        ea = AW'((a + i) % DEPTH);
        checkOutput("wr_wen", DW'(sram_wen), DW'(1));
        checkOutput("wr_addr", DW'(sram_addr), DW'(ea));
        checkOutput("wr_din", sram_din, d);
        refMem[ea] = d;
        i++;
      end else begin
        checkOutput("wr_gap_wen", DW'(sram_wen), '0);
      end
      cyc++;
    end
    checkOutput("wr_words", DW'(i), DW'(len + 1));
    @(negedge clk);
    wd_valid = 1'b0;
    #1;
    checkOutput("wr_busy_done", DW'(busy), '0);
    checkOutput("wr_cmd_ready", DW'(cmd_ready), DW'(1));
  endtask

  // mode 0: rd_ready held high, 1: ready pattern 1-0-0-1, 2: random ready
  task automatic doRead(input int a, input int len, input int mode);
    int got = 0;
    int issued = 0;
    int popped = 0;
    int cyc = 0;
    int firstValid = -1;
    logic r, p;
    logic holdValid = 1'b0;
    logic [DW-1:0] holdData = '0;
    logic holdLast = 1'b0;
    logic [AW-1:0] ea;
    applyStimulus(1'b1, a, len);
    while (got <= len && cyc < 6 * (len + 1) + 20) begin
      @(negedge clk);
      cyc++;
      case (mode)
        0: r = 1'b1;
        1: r = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      rd_ready = r;
      #1;
      p = rd_valid && r;
      if (holdValid) begin
        checkOutput("rd_hold_valid", DW'(rd_valid), DW'(1));
        checkOutput("rd_hold_data", rd_data, holdData);
        checkOutput("rd_hold_last", DW'(rd_last), DW'(holdLast));
      end
      if (sram_ren) begin
        issued++;
        ea = AW'((a + issued - 1) % DEPTH);
        checkOutput("rd_issue_addr", DW'(sram_addr), DW'(ea));
        checkOutput("rd_no_overflow", DW'((issued - popped - int'(p)) <= 2), DW'(1));
      end
      holdValid = 1'b0;
      if (rd_valid) begin
        if (firstValid < 0) firstValid = cyc;
        if (mode == 0) checkOutput("rd_throughput", DW'(cyc), DW'(firstValid + got));
        if (r) begin
          ea = AW'((a + got) % DEPTH);
          checkOutput("rd_data", rd_data, refMem[ea]);
          checkOutput("rd_last", DW'(rd_last), DW'(got == len));
          got++;
          popped++;
        end else begin
          holdValid = 1'b1;
          holdData  = rd_data;
          holdLast  = rd_last;
        end
      end
    end
    checkOutput("rd_words", DW'(got), DW'(len + 1));
    checkOutput("rd_latency", DW'(firstValid), DW'(3));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rd_ready = 1'b1;
      #1;
      if (sram_ren) issued++;
      if (k == 3) checkOutput("rd_extra_valid", DW'(rd_valid), '0);
    end
    checkOutput("rd_issue_count", DW'(issued), DW'(len + 1));
    checkOutput("rd_busy_done", DW'(busy), '0);
    checkOutput("rd_cmd_ready", DW'(cmd_ready), DW'(1));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int k = 0; k < DEPTH; k++) begin
      sramMem[k] = '0;
      refMem[k]  = '0;
    end
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = '0; cmd_len = '0;
    wd_valid = 1'b0; wd_data = '0; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkResetOutputs("init");
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("release_ready_low", DW'(cmd_ready), '0);
    @(negedge clk);
    #1;
    checkOutput("release_ready_high", DW'(cmd_ready), DW'(1));

    doWrite(0, 3, 1'b0, 32'hA0, 1'b0);
    doRead(0, 3, 0);
    doWrite(9'h1FE, 3, 1'b0, 32'hB0, 1'b0);
    doRead(9'h1FE, 3, 0);
    doWrite(16, 7, 1'b1, '0, 1'b1);
    doRead(16, 7, 1);
    doRead(2, 0, 0);
    doWrite(5, 511, 1'b0, '0, 1'b1);
    doRead(5, 511, 0);
    for (int t = 0; t < 10; t++) begin
      int ra, rl;
      ra = $urandom_range(0, DEPTH - 1);
      rl = $urandom_range(0, 20);
      doWrite(ra, rl, 1'($urandom_range(0, 1)), '0, 1'b1);
      doRead(ra, rl, 2);
    end

    // Reset with both FIFO entries occupied
    doWrite(0, 7, 1'b0, 32'hC0, 1'b0);
    rd_ready = 1'b0;
    applyStimulus(1'b1, 0, 7);
    repeat (4) @(negedge clk);
    #1;
    checkOutput("pre_rst_valid", DW'(rd_valid), DW'(1));
    checkOutput("pre_rst_data", rd_data, 32'hC0);
    #1;
    rst = 1'b1;
    #1;
    checkResetOutputs("mid_rst");
    @(negedge clk);
    #1;
    checkResetOutputs("held_rst");
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("post_rst_ready", DW'(cmd_ready), DW'(1));
    doWrite(40, 2, 1'b0, 32'hD0, 1'b0);
    doRead(40, 2, 0);

    // Reset while a read is still in flight; its returning word must vanish
    rd_ready = 1'b1;
    applyStimulus(1'b1, 40, 2);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checkOutput("discard_valid", DW'(rd_valid), '0);
    end
    checkOutput("discard_idle", DW'(busy), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
